// File: rtl/tank_if.sv
// Signal bundle between the level controller (master) and the tank plant model (slave).
interface tank_if #(
  parameter int WIDTH = 8
) ();
  logic             pump;
  logic             drain;
  logic             clr;
  logic             fault_lh;
  logic             fault_ll;
  logic [WIDTH-1:0] level;
  logic             lh;
  logic             ll;
  logic [1:0]       phase;
  logic             tick;
  logic             overflow;
  logic             dry;

  modport master (
    output pump, drain, clr, fault_lh, fault_ll,
    input  level, lh, ll, phase, tick, overflow, dry
  );

  modport slave (
    input  pump, drain, clr, fault_lh, fault_ll,
    output level, lh, ll, phase, tick, overflow, dry
  );
endinterface

// File: rtl/tank_level_model.sv
// Behavioural water-tank plant: saturating level integrator, level sensors, phase tracker.
// Define SENSOR_FAULT_EN to let fault_lh/fault_ll force the sensor outputs.
module tank_level_model #(
  parameter int WIDTH      = 8,
  parameter int FILL_RATE  = 4,
  parameter int DRAIN_RATE = 1,
  parameter int LOW_THR    = 16,
  parameter int HIGH_THR   = 240,
  parameter int TICK_DIV   = 4
) (
  input  logic clk,
  input  logic rst,
  tank_if.slave tif
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  localparam logic signed [WIDTH+1:0] ZERO_S  = '0;
  localparam logic signed [WIDTH+1:0] FULL_S  = $signed({2'b00, {WIDTH{1'b1}}});
  localparam logic signed [WIDTH+1:0] FILL_S  = (WIDTH+2)'(FILL_RATE);
  localparam logic signed [WIDTH+1:0] DRAIN_S = (WIDTH+2)'(DRAIN_RATE);
  localparam logic [WIDTH-1:0] LOW_L  = WIDTH'(LOW_THR);
  localparam logic [WIDTH-1:0] HIGH_L = WIDTH'(HIGH_THR);

  typedef enum logic [1:0] {
    PH_LOW     = 2'd0,
    PH_RISING  = 2'd1,
    PH_HIGH    = 2'd2,
    PH_FALLING = 2'd3
  } phase_t;

  function automatic logic [WIDTH-1:0] sat_level(input logic signed [WIDTH+1:0] s);
    if (s > FULL_S)
      return {WIDTH{1'b1}};
    else if (s < ZERO_S)
      return '0;
    else
      return s[WIDTH-1:0];
  endfunction

  logic [CNT_W-1:0]         tick_cnt;
  logic                     vld_p0;
  logic signed [WIDTH+1:0]  fill_s;
  logic signed [WIDTH+1:0]  drain_s;
  logic signed [WIDTH+1:0]  sum_p0;
  logic [WIDTH-1:0]         level_p0;
  logic                     ovf_evt_p0;
  logic                     dry_evt_p0;
  logic                     above_low_p0;
  logic                     at_high_p0;
  logic                     lvl_up_p0;
  logic                     lvl_dn_p0;
  phase_t                   phase_p0;

  logic [WIDTH-1:0]         level_p1;
  logic                     lh_p1;
  logic                     ll_p1;
  logic                     overflow_p1;
  logic                     dry_p1;
  phase_t                   phase_p1;

  assign vld_p0 = (tick_cnt == CNT_LAST);

  // Stage p0: integrate on tick cycles with saturation to [0, full scale]
  always_comb begin
    fill_s       = tif.pump  ? FILL_S  : ZERO_S;
    drain_s      = tif.drain ? DRAIN_S : ZERO_S;
    sum_p0       = $signed({2'b00, level_p1}) + fill_s - drain_s;
    level_p0     = vld_p0 ? sat_level(sum_p0) : level_p1;
    ovf_evt_p0   = vld_p0 && (sum_p0 > FULL_S);
    dry_evt_p0   = vld_p0 && (sum_p0 < ZERO_S);
    above_low_p0 = (level_p0 > LOW_L);
    at_high_p0   = (level_p0 >= HIGH_L);
    lvl_up_p0    = (level_p0 > level_p1);
    lvl_dn_p0    = (level_p0 < level_p1);
  end

  // Threshold checks win over direction so a large step lands straight in LOW or HIGH.
  always_comb begin
    phase_p0 = phase_p1;
    case (phase_p1)
      PH_LOW: begin
        if (at_high_p0)        phase_p0 = PH_HIGH;
        else if (above_low_p0) phase_p0 = PH_RISING;
      end
      PH_RISING: begin
        if (at_high_p0)         phase_p0 = PH_HIGH;
        else if (!above_low_p0) phase_p0 = PH_LOW;
        else if (lvl_dn_p0)     phase_p0 = PH_FALLING;
      end
      PH_HIGH: begin
        if (!above_low_p0)   phase_p0 = PH_LOW;
        else if (!at_high_p0) phase_p0 = PH_FALLING;
      end
      PH_FALLING: begin
        if (!above_low_p0)  phase_p0 = PH_LOW;
        else if (at_high_p0) phase_p0 = PH_HIGH;
        else if (lvl_up_p0)  phase_p0 = PH_RISING;
      end
      default: phase_p0 = PH_LOW;
    endcase
  end

  // Stage p1: registered plant state; saturation events take priority over clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt    <= '0;
      level_p1    <= '0;
      lh_p1       <= 1'b0;
      ll_p1       <= 1'b1;
      overflow_p1 <= 1'b0;
      dry_p1      <= 1'b0;
      phase_p1    <= PH_LOW;
    end else begin
      tick_cnt    <= vld_p0 ? '0 : tick_cnt + CNT_W'(1);
      level_p1    <= level_p0;
      lh_p1       <= at_high_p0;
      ll_p1       <= !above_low_p0;
      overflow_p1 <= ovf_evt_p0 | (overflow_p1 & ~tif.clr);
      dry_p1      <= dry_evt_p0 | (dry_p1 & ~tif.clr);
      phase_p1    <= phase_p0;
    end
  end

  assign tif.level    = level_p1;
  assign tif.phase    = phase_p1;
  assign tif.tick     = vld_p0;
  assign tif.overflow = overflow_p1;
  assign tif.dry      = dry_p1;

`ifdef SENSOR_FAULT_EN
  assign tif.lh = lh_p1 | tif.fault_lh;
  assign tif.ll = ll_p1 & ~tif.fault_ll;
`else
  logic unused_fault;
  assign unused_fault = tif.fault_lh ^ tif.fault_ll;
  assign tif.lh = lh_p1;
  assign tif.ll = ll_p1;
`endif

endmodule

// File: tb/tb_tank_level_model.sv
// Directed plus randomized bench for tank_level_model against an arithmetic tank model.
module tb_tank_level_model;
  localparam int WIDTH      = 8;
  localparam int FILL_RATE  = 4;
  localparam int DRAIN_RATE = 1;
  localparam int LOW_THR    = 16;
  localparam int HIGH_THR   = 240;
  localparam int TICK_DIV   = 4;
  localparam int FULL       = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tank_if #(.WIDTH(WIDTH)) tif ();

  tank_level_model #(
    .WIDTH(WIDTH), .FILL_RATE(FILL_RATE), .DRAIN_RATE(DRAIN_RATE),
    .LOW_THR(LOW_THR), .HIGH_THR(HIGH_THR), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tif(tif)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference tank state
  int m_level, m_cnt, m_phase, m_ticks;
  bit m_ovf, m_dry;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_level = 0;
    m_cnt   = 0;
    m_phase = 0;
    m_ovf   = 0;
    m_dry   = 0;
  endtask

  // Phase from where the level sits and which way it just moved.
  function automatic int next_phase(input int prev, input int old_lvl, input int new_lvl);
    if (new_lvl <= LOW_THR)  return 0;
    if (new_lvl >= HIGH_THR) return 2;
    if (new_lvl > old_lvl)   return 1;
    if (new_lvl < old_lvl)   return 3;
    if (prev == 0)           return 1;
    if (prev == 2)           return 3;
    return prev;
  endfunction

  task automatic model_edge();
    int s;
    int old_lvl;
    bit ovf_ev;
    bit dry_ev;
    if (rst) begin
      model_reset();
    end else begin
      old_lvl = m_level;
      ovf_ev  = 0;
      dry_ev  = 0;
      if (m_cnt == TICK_DIV - 1) begin
        s = m_level + (tif.pump ? FILL_RATE : 0) - (tif.drain ? DRAIN_RATE : 0);
        if (s > FULL) begin
          m_level = FULL;
          ovf_ev  = 1;
        end else if (s < 0) begin
          m_level = 0;
          dry_ev  = 1;
        end else begin
          m_level = s;
        end
        m_ticks++;
      end
      m_ovf   = ovf_ev ? 1'b1 : (tif.clr ? 1'b0 : m_ovf);
      m_dry   = dry_ev ? 1'b1 : (tif.clr ? 1'b0 : m_dry);
      m_phase = next_phase(m_phase, old_lvl, m_level);
      m_cnt   = (m_cnt + 1) % TICK_DIV;
    end
  endtask

  task automatic check_all(input string tag);
    bit exp_lh;
    bit exp_ll;
    exp_lh = (m_level >= HIGH_THR);
    exp_ll = (m_level <= LOW_THR);
`ifdef SENSOR_FAULT_EN
    exp_lh = exp_lh | tif.fault_lh;
    exp_ll = exp_ll & ~tif.fault_ll;
`endif
    chk({tag, ".level"},    32'(tif.level),    32'(m_level));
    chk({tag, ".tick"},     32'(tif.tick),     32'(m_cnt == TICK_DIV - 1));
    chk({tag, ".lh"},       32'(tif.lh),       32'(exp_lh));
    chk({tag, ".ll"},       32'(tif.ll),       32'(exp_ll));
    chk({tag, ".phase"},    32'(tif.phase),    32'(m_phase));
    chk({tag, ".overflow"}, 32'(tif.overflow), 32'(m_ovf));
    chk({tag, ".dry"},      32'(tif.dry),      32'(m_dry));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic run_ticks(input string tag, input int n);
    int target;
    int guard;
    target = m_ticks + n;
    guard  = 0;
    while (m_ticks < target && guard < (n + 1) * TICK_DIV) begin
      step(tag);
      guard++;
    end
    chk({tag, ".tick_budget"}, 32'(m_ticks), 32'(target));
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step("rst_pulse");
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tif.pump     = 1'b0;
    tif.drain    = 1'b0;
    tif.clr      = 1'b0;
    tif.fault_lh = 1'b0;
    tif.fault_ll = 1'b0;
    m_ticks      = 0;
    model_reset();

    step("reset");
    step("reset");
    rst = 1'b0;

    for (int i = 0; i < 20; i++) step("idle");

    tif.pump = 1'b1;
    run_ticks("fill_a", 4);
    chk("fill_t4.level", 32'(tif.level), 32'd16);
    chk("fill_t4.ll",    32'(tif.ll),    32'd1);
    run_ticks("fill_b", 1);
    chk("fill_t5.level", 32'(tif.level), 32'd20);
    chk("fill_t5.ll",    32'(tif.ll),    32'd0);
    chk("fill_t5.phase", 32'(tif.phase), 32'd1);
    run_ticks("fill_c", 55);
    chk("fill_t60.level", 32'(tif.level), 32'd240);
    chk("fill_t60.lh",    32'(tif.lh),    32'd1);
    chk("fill_t60.phase", 32'(tif.phase), 32'd2);
    run_ticks("fill_d", 4);
    chk("fill_t64.level",    32'(tif.level),    32'd255);
    chk("fill_t64.overflow", 32'(tif.overflow), 32'd1);
    run_ticks("fill_e", 3);
    chk("fill_hold.level", 32'(tif.level), 32'd255);

    tif.pump = 1'b0;
    reset_pulse();
    tif.drain = 1'b1;
    run_ticks("dry_a", 2);
    chk("dry.level", 32'(tif.level), 32'd0);
    chk("dry.flag",  32'(tif.dry),   32'd1);
    tif.drain = 1'b0;
    tif.clr   = 1'b1;
    step("clr");
    tif.clr = 1'b0;
    chk("clr.dry", 32'(tif.dry), 32'd0);
    tif.drain = 1'b1;
    tif.clr   = 1'b1;
    run_ticks("clr_vs_set", 1);
    chk("set_wins.dry", 32'(tif.dry), 32'd1);
    tif.drain = 1'b0;
    step("clr2");
    tif.clr = 1'b0;
    chk("clr2.dry", 32'(tif.dry), 32'd0);

    reset_pulse();
    tif.pump = 1'b1;
    run_ticks("to100", 25);
    chk("to100.level", 32'(tif.level), 32'd100);
    chk("to100.phase", 32'(tif.phase), 32'd1);
    tif.drain = 1'b1;
    run_ticks("both", 1);
    chk("both.level", 32'(tif.level), 32'd103);
    tif.pump = 1'b0;
    run_ticks("drain", 1);
    chk("drain.level", 32'(tif.level), 32'd102);
    chk("drain.phase", 32'(tif.phase), 32'd3);

    tif.drain = 1'b0;
    reset_pulse();
    tif.pump = 1'b1;
    run_ticks("to120", 30);
    chk("to120.level", 32'(tif.level), 32'd120);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.level", 32'(tif.level), 32'd0);
    step("async_rst_hold");
    rst = 1'b0;

    run_ticks("to48", 12);
    tif.fault_lh = 1'b1;
    run_ticks("fault_lh", 1);
`ifdef SENSOR_FAULT_EN
    chk("fault_lh.lh", 32'(tif.lh), 32'd1);
`else
    chk("fault_lh.lh", 32'(tif.lh), 32'd0);
`endif
    chk("fault_lh.phase", 32'(tif.phase), 32'd1);
    tif.fault_lh = 1'b0;
    tif.pump     = 1'b0;
    reset_pulse();
    tif.fault_ll = 1'b1;
    step("fault_ll");
`ifdef SENSOR_FAULT_EN
    chk("fault_ll.ll", 32'(tif.ll), 32'd0);
`else
    chk("fault_ll.ll", 32'(tif.ll), 32'd1);
`endif
    tif.fault_ll = 1'b0;

    for (int seg = 0; seg < 3; seg++) begin
      int pb;
      int db;
      pb = (seg == 0) ? 75 : (seg == 1) ? 15 : 50;
      db = (seg == 0) ? 25 : (seg == 1) ? 80 : 50;
      for (int i = 0; i < 400; i++) begin
        tif.pump     = ($urandom_range(0, 99) < pb);
        tif.drain    = ($urandom_range(0, 99) < db);
        tif.clr      = ($urandom_range(0, 31) == 0);
        tif.fault_lh = ($urandom_range(0, 7) == 0);
        tif.fault_ll = ($urandom_range(0, 7) == 0);
        rst          = ($urandom_range(0, 299) == 0);
        step("rand");
      end
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
